// File: rtl/wb_packet_arbiter_if.sv
// Write-back packet arbiter bus: requester bundle in, packet SRAM write beat out.
// master = arbiter side, slave = requesters plus SRAM controller side.
interface wb_packet_arbiter_if #(
    parameter int NUM_REQS = 5,
    parameter int DATA_W   = 16,
    parameter int LEN_W    = 4,
    parameter int SRC_W    = 3
);
    logic [NUM_REQS-1:0]        reqs;
    logic [NUM_REQS*LEN_W-1:0]  req_len;
    logic [NUM_REQS*DATA_W-1:0] req_data;
    logic [NUM_REQS-1:0]        grants;
    logic [NUM_REQS-1:0]        beat_ack;
    logic                       out_valid;
    logic [DATA_W-1:0]          out_data;
    logic                       out_last;
    logic [SRC_W-1:0]           out_src;
    logic                       out_ready;
    logic                       aborted;

    modport master (
        input  reqs,
        input  req_len,
        input  req_data,
        input  out_ready,
        output grants,
        output beat_ack,
        output out_valid,
        output out_data,
        output out_last,
        output out_src,
        output aborted
    );

    modport slave (
        output reqs,
        output req_len,
        output req_data,
        output out_ready,
        input  grants,
        input  beat_ack,
        input  out_valid,
        input  out_data,
        input  out_last,
        input  out_src,
        input  aborted
    );
endinterface

// File: rtl/wb_packet_arbiter.sv
// Round-robin burst arbiter for write-back packets onto the packet SRAM port.
// Define WB_ARB_DECODER_PRIORITY_EN to give requester 0 (decoder) strict priority.
module wb_packet_arbiter #(
    parameter int NUM_REQS  = 5,
    parameter int DATA_W    = 16,
    parameter int MAX_BEATS = 16,
    localparam int LEN_W    = $clog2(MAX_BEATS),
    localparam int SRC_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    wb_packet_arbiter_if.master bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [SRC_W-1:0]   win_q, win_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               aborted_q, aborted_d;

    logic [NUM_REQS-1:0] hi_mask;
    logic [NUM_REQS-1:0] hi_reqs;
    logic                found;
    logic [SRC_W-1:0]    pick;
    logic [SRC_W-1:0]    ptr_nxt;
    logic [LEN_W-1:0]    len_pick;

    logic                req_win;
    logic [DATA_W-1:0]   data_win;

    logic [NUM_REQS-1:0] gnt;
    logic [NUM_REQS-1:0] ack;
    logic                valid;
    logic                last;
    logic [DATA_W-1:0]   data;
    logic [SRC_W-1:0]    src;

    // Rotating priority: requests at or above ptr beat those below it.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            hi_mask[i] = (SRC_W'(i) >= ptr_q);
        end
        hi_reqs = bus.reqs & hi_mask;
        found   = |bus.reqs;
        pick    = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (bus.reqs[i]) begin
                pick = SRC_W'(i);
            end
        end
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (hi_reqs[i]) begin
                pick = SRC_W'(i);
            end
        end
`ifdef WB_ARB_DECODER_PRIORITY_EN
        if (bus.reqs[0]) begin
            pick = '0;
        end
`endif
    end

    always_comb begin
        ptr_nxt = '0;
        if (pick != SRC_W'(NUM_REQS - 1)) begin
            ptr_nxt = pick + 1'b1;
        end
`ifdef WB_ARB_DECODER_PRIORITY_EN
        // The decoder jumps the queue without disturbing PE rotation.
        if (pick == '0) begin
            ptr_nxt = ptr_q;
        end
`endif
    end

    assign len_pick = bus.req_len[pick*LEN_W +: LEN_W];
    assign req_win  = bus.reqs[win_q];
    assign data_win = bus.req_data[win_q*DATA_W +: DATA_W];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        aborted_d = 1'b0;
        gnt       = '0;
        ack       = '0;
        valid     = 1'b0;
        last      = 1'b0;
        data      = '0;
        src       = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = pick;
                    len_d   = len_pick;
                    cnt_d   = '0;
                    ptr_d   = ptr_nxt;
                    state_d = BURST;
                end
            end
            BURST: begin
                gnt   = NUM_REQS'(1) << win_q;
                src   = win_q;
                data  = data_win;
                valid = req_win;
                last  = req_win && (cnt_q == len_q);
                if (!req_win) begin
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else if (bus.out_ready) begin
                    ack   = gnt;
                    cnt_d = cnt_q + 1'b1;
                    if (last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            aborted_q <= aborted_d;
        end
    end

    // Outputs are forced quiet while reset is held.
    assign bus.grants    = reset ? '0 : gnt;
    assign bus.beat_ack  = reset ? '0 : ack;
    assign bus.out_valid = reset ? 1'b0 : valid;
    assign bus.out_last  = reset ? 1'b0 : last;
    assign bus.out_data  = reset ? '0 : data;
    assign bus.out_src   = reset ? '0 : src;
    assign bus.aborted   = aborted_q;

endmodule

// File: tb/tb_wb_packet_arbiter.sv
// Directed scoreboard bench for wb_packet_arbiter.
// Honours WB_ARB_DECODER_PRIORITY_EN for the priority scenario.
module tb_wb_packet_arbiter;
    localparam int N  = 5;
    localparam int DW = 16;
    localparam int MB = 16;
    localparam int LW = 4;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_packet_arbiter_if #(.NUM_REQS(N), .DATA_W(DW), .LEN_W(LW), .SRC_W(SW)) bus ();

    wb_packet_arbiter #(.NUM_REQS(N), .DATA_W(DW), .MAX_BEATS(MB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [SW-1:0] src;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t sbq[$];
    bit    rdy_pat[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    bit rq_on[N];
    int rq_left[N];
    int rq_len[N];
    int rq_seq[N];
    int rq_drop[N];
    int rq_bursts[N];
    int exp_seq[N];

    logic [N-1:0]  s_gnt, s_ack, prev_gnt;
    logic          s_valid, s_last, s_abort, s_ready;
    logic [DW-1:0] s_data, hold_data;
    logic [SW-1:0] s_src;
    bit            held;
    int            ack_total;
    int            used;

    function automatic logic [DW-1:0] dval(int i, int s);
        return DW'(i * 4096 + (s & 32'hfff));
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.reqs[i]                = rq_on[i];
            bus.req_len[i*LW +: LW]    = LW'(rq_len[i]);
            bus.req_data[i*DW +: DW]   = dval(i, rq_seq[i]);
        end
    endtask

    task automatic req(int i, int len, int bursts, int drop);
        rq_on[i]     = 1'b1;
        rq_len[i]    = len;
        rq_left[i]   = len + 1;
        rq_bursts[i] = bursts;
        rq_drop[i]   = drop;
    endtask

    task automatic expect_burst(int i, int nbeats, int len);
        beat_t b;
        for (int k = 0; k < nbeats; k++) begin
            b.src  = SW'(i);
            b.data = dval(i, exp_seq[i]);
            b.last = (k == len);
            exp_seq[i]++;
            sbq.push_back(b);
        end
    endtask

    // One clock: sample at negedge, then update requesters after posedge.
    task automatic cycle();
        beat_t b;
        @(negedge clk);
        s_gnt   = bus.grants;
        s_ack   = bus.beat_ack;
        s_valid = bus.out_valid;
        s_last  = bus.out_last;
        s_data  = bus.out_data;
        s_src   = bus.out_src;
        s_abort = bus.aborted;
        s_ready = bus.out_ready;
        if (s_valid && s_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_beat_src", 32'(s_src), 32'hffff_ffff);
            end else begin
                b = sbq.pop_front();
                check("beat_src", 32'(s_src), 32'(b.src));
                check("beat_data", 32'(s_data), 32'(b.data));
                check("beat_last", 32'(s_last), 32'(b.last));
                check("beat_ack", 32'(s_ack), 32'(N'(1) << b.src));
            end
            if (s_ack != '0) ack_total++;
        end else begin
            check("ack_no_xfer", 32'(s_ack), 32'h0);
        end
        if (held && s_valid) check("hold_data", 32'(s_data), 32'(hold_data));
        held      = s_valid && !s_ready;
        hold_data = s_data;
        if (s_gnt != '0 && prev_gnt != '0 && s_gnt != prev_gnt)
            check("idle_gap", 32'(prev_gnt), 32'h0);
        prev_gnt = s_gnt;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (s_ack[i]) begin
                rq_seq[i]++;
                rq_left[i]--;
                if (rq_drop[i] > 0) begin
                    rq_drop[i]--;
                    if (rq_drop[i] == 0) rq_on[i] = 1'b0;
                end
                if (rq_left[i] == 0) begin
                    if (rq_bursts[i] > 1) begin
                        rq_bursts[i]--;
                        rq_left[i] = rq_len[i] + 1;
                    end else begin
                        rq_on[i] = 1'b0;
                    end
                end
            end
        end
        if (rdy_pat.size() > 0) bus.out_ready = rdy_pat.pop_front();
        drive();
    endtask

    task automatic wait_drain(input int budget, output int n);
        n = 0;
        while (sbq.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        check("drain", 32'(sbq.size()), 32'h0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) rq_on[i] = 1'b0;
        bus.out_ready = 1'b1;
        drive();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        held  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        prev_gnt      = '0;
        held          = 1'b0;
        ack_total     = 0;
        for (int i = 0; i < N; i++) begin
            rq_on[i] = 1'b0; rq_left[i] = 0; rq_len[i] = 0;
            rq_seq[i] = 0; rq_drop[i] = 0; rq_bursts[i] = 0; exp_seq[i] = 0;
        end
        // Reset held with every requester asserted
        for (int i = 0; i < N; i++) req(i, 0, 1, 0);
        drive();
        cycle();
        check("rst_grants", 32'(s_gnt), 32'h0);
        check("rst_valid", 32'(s_valid), 32'h0);
        check("rst_last", 32'(s_last), 32'h0);
        check("rst_data", 32'(s_data), 32'h0);
        check("rst_src", 32'(s_src), 32'h0);
        check("rst_abort", 32'(s_abort), 32'h0);
        cycle();
        for (int i = 0; i < N; i++) rq_on[i] = 1'b0;
        drive();
        reset = 1'b0;
        cycle();
        check("idle_grants", 32'(s_gnt), 32'h0);
        check("ptr_rst", 32'(dut.ptr_q), 32'h0);

        // Single 4-beat burst from requester 2
        req(2, 3, 1, 0);
        expect_burst(2, 4, 3);
        drive();
        cycle();
        check("t1_req_cycle_gnt", 32'(s_gnt), 32'h0);
        cycle();
        check("t1_gnt", 32'(s_gnt), 32'h04);
        check("t1_src", 32'(s_src), 32'h2);
        wait_drain(10, used);
        check("t1_len", 32'(used), 32'h3);
        cycle();
        check("t1_idle_after", 32'(s_gnt), 32'h0);
        check("t1_ptr", 32'(dut.ptr_q), 32'h3);

        // All requesters, length 0: order 0,1,2,3,4,0 with one idle cycle each
        do_reset();
        for (int i = 0; i < N; i++) req(i, 0, (i == 0) ? 2 : 1, 0);
        for (int i = 0; i < N; i++) expect_burst(i, 1, 0);
        expect_burst(0, 1, 0);
        drive();
        wait_drain(40, used);
        check("t2_cycles", 32'(used), 32'd12);
        cycle();
        check("t2_idle_after", 32'(s_gnt), 32'h0);

        // Backpressure: ready 1,0,1,0,1 over a 3-beat burst
        do_reset();
        req(1, 2, 1, 0);
        expect_burst(1, 3, 2);
        rdy_pat   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        ack_total = 0;
        drive();
        wait_drain(20, used);
        check("t3_cycles", 32'(used), 32'd6);
        check("t3_acks", 32'(ack_total), 32'd3);

        // Requester 3 drops after one of four beats; 4 is next
        do_reset();
        req(3, 3, 1, 1);
        req(4, 0, 1, 0);
        expect_burst(3, 1, 3);
        expect_burst(4, 1, 0);
        drive();
        cycle();
        check("t4_c0_gnt", 32'(s_gnt), 32'h0);
        cycle();
        check("t4_c1_gnt", 32'(s_gnt), 32'h08);
        check("t4_c1_valid", 32'(s_valid), 32'h1);
        cycle();
        check("t4_c2_valid", 32'(s_valid), 32'h0);
        check("t4_c2_abort", 32'(s_abort), 32'h0);
        cycle();
        check("t4_c3_abort", 32'(s_abort), 32'h1);
        check("t4_c3_gnt", 32'(s_gnt), 32'h0);
        cycle();
        check("t4_c4_gnt", 32'(s_gnt), 32'h10);
        check("t4_c4_abort", 32'(s_abort), 32'h0);
        check("t4_empty", 32'(sbq.size()), 32'h0);
        cycle();

        // Requester 1 moves ptr to 2, then 0 and 4 compete
        do_reset();
        req(1, 1, 1, 0);
        expect_burst(1, 2, 1);
        drive();
        wait_drain(10, used);
        cycle();
        req(0, 0, 1, 0);
        req(4, 1, 1, 0);
`ifdef WB_ARB_DECODER_PRIORITY_EN
        expect_burst(0, 1, 0);
        expect_burst(4, 2, 1);
`else
        expect_burst(4, 2, 1);
        expect_burst(0, 1, 0);
`endif
        drive();
        cycle();
        cycle();
`ifdef WB_ARB_DECODER_PRIORITY_EN
        check("t5_ptr_mid", 32'(dut.ptr_q), 32'h2);
`else
        check("t5_ptr_mid", 32'(dut.ptr_q), 32'h0);
`endif
        wait_drain(20, used);
`ifdef WB_ARB_DECODER_PRIORITY_EN
        check("t5_ptr_end", 32'(dut.ptr_q), 32'h0);
`else
        check("t5_ptr_end", 32'(dut.ptr_q), 32'h1);
`endif
        cycle();

        // Reset during beat 2 of an 8-beat burst
        do_reset();
        req(2, 7, 1, 0);
        expect_burst(2, 2, 7);
        drive();
        cycle();
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        check("t6_rst_gnt", 32'(s_gnt), 32'h0);
        check("t6_rst_valid", 32'(s_valid), 32'h0);
        reset    = 1'b0;
        rq_on[2] = 1'b0;
        drive();
        cycle();
        check("t6_gnt", 32'(s_gnt), 32'h0);
        check("t6_valid", 32'(s_valid), 32'h0);
        check("t6_abort", 32'(s_abort), 32'h0);
        check("t6_ptr", 32'(dut.ptr_q), 32'h0);
        check("t6_empty", 32'(sbq.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_packet_arbiter.md
Name: wb_packet_arbiter

Overview:
- Parametrised successor to the single-cycle round-robin arbiter that serialises write-back packet requests from the packet decoder and the Edge PEs.
- Arbitrates NUM_REQS requesters onto one packet write port; a grant is locked for a multi-beat burst of variable length.
- Muxes the winner's data, handshakes with the downstream packet SRAM controller (valid/ready), and reports the source ID.
- Sits between the Edge PE/decoder req_WB_Packet lines and the packet SRAM write path.

Parameters:
- NUM_REQS, 5, number of requesters; index 0 is the packet decoder, 1..NUM_REQS-1 are Edge PEs.
- DATA_W, 16, packet beat width in bits.
- MAX_BEATS, 16, maximum beats per burst; must be a power of 2 and at least 2.
- Derived: LEN_W = $clog2(MAX_BEATS); SRC_W = $clog2(NUM_REQS).

Ports:
- clk  in  1  global clock
- reset  in  1  synchronous, active-high reset
- reqs  in  NUM_REQS  per-requester burst request; held high until the last beat is acked
- req_len  in  NUM_REQS*LEN_W  per-requester burst length minus 1; sampled at grant
- req_data  in  NUM_REQS*DATA_W  per-requester current beat data
- grants  out  NUM_REQS  one-hot; high for the granted requester for the whole burst
- beat_ack  out  NUM_REQS  one-hot; a pulse means the requester's current beat was consumed and the next beat must be presented
- out_valid  out  1  beat valid toward the packet SRAM
- out_data  out  DATA_W  winner's req_data
- out_last  out  1  final beat of the burst
- out_src  out  SRC_W  winner index
- out_ready  in  1  downstream accepts the beat
- aborted  out  1  one-cycle pulse when a burst is terminated early

Behaviour:
- Reset values (registered, synchronous): state=IDLE, ptr=0, winner=0, len_q=0, beat_cnt=0, aborted=0.
- Combinational outputs under reset: grants=0, beat_ack=0, out_valid=0, out_last=0, out_data=0, out_src=0.
- States: IDLE, BURST.
- IDLE:
  - Outputs are all zero.
  - If any reqs bit is set, the winner is the first set index scanning ptr, ptr+1, ... with wrap modulo NUM_REQS.
  - At the clock edge: winner<=that index, len_q<=req_len[winner], beat_cnt<=0, ptr<=(winner+1) mod NUM_REQS, state<=BURST.
  - No requests: stay in IDLE, ptr unchanged.
- BURST:
  - grants[winner]=1, out_src=winner, out_data=req_data[winner].
  - out_valid=reqs[winner]; out_last=out_valid && (beat_cnt==len_q).
  - Beat transfer = out_valid && out_ready. On a transfer: beat_ack[winner]=1 in the same cycle (combinational) and beat_cnt<=beat_cnt+1.
  - Transfer with out_last=1: state<=IDLE. There is exactly one idle cycle between bursts; back-to-back grants are not allowed.
  - out_ready low: hold all state; out_data and out_last remain stable only while the requester holds its data.
  - reqs[winner] drops before the last beat: out_valid=0 that cycle, aborted<=1 for one cycle (visible next cycle), state<=IDLE. ptr has already advanced, so there is no retry priority.
- Latency: request to first out_valid is 1 cycle. Minimum burst occupancy is len+1 transfer cycles plus 1 IDLE cycle.
- Requests from non-winners during BURST are ignored and must be held by the requester.
- req_len changes after grant are ignored.
- len=MAX_BEATS-1 gives MAX_BEATS beats; beat_cnt is LEN_W bits and never wraps within a legal burst.
- NUM_REQS=1: ptr stays 0; the block degenerates to a burst pass-through.
- reset asserted mid-burst: the next cycle is IDLE with all outputs zero; the partial burst is dropped without an aborted pulse.

Optional Feature:
- Macro WB_ARB_DECODER_PRIORITY_EN.
- Defined: in IDLE, reqs[0] (packet decoder) wins unconditionally over all PEs. ptr is not updated when index 0 wins, so PE fairness among 1..NUM_REQS-1 is preserved.
- Undefined: index 0 takes part in plain round-robin like every other requester.

Test Plan:
- Reset, then reqs=5'b00100, req_len[2]=3, out_ready=1 -> grants=5'b00100 from cycle 1; 4 beats with out_last on the 4th; out_src=2; ptr=3; one IDLE cycle follows.
- reqs=5'b11111 held, all lengths 0, ptr=0 -> grant order 0,1,2,3,4,0 with every grant separated by one IDLE cycle.
- Burst len=2 with out_ready toggling 1,0,1,0,1 -> 3 beat_ack pulses, only on ready cycles; out_data stable while ready=0.
- Requester 3 drops reqs after 1 of 4 beats -> out_valid=0 that cycle, aborted pulses 1 cycle later, state returns to IDLE, next requester granted.
- With WB_ARB_DECODER_PRIORITY_EN, reqs=5'b10011 and ptr=1 -> index 0 is granted first, then 1, then 4; ptr still points at 1 after the decoder burst.
- Reset asserted during beat 2 of a len=7 burst -> the next cycle has grants=0, out_valid=0, aborted=0 and ptr=0.
